ram_loader: RTL and testbench

Parametrised successor of the single-port word RAM with UART code download. It provides a word-wide CPU read/write port with per-byte write enables, an optional registered read, and a framed UART loader that writes arbitrary byte ranges with checksum verification. It sits between the UART receiver and the CPU core.

---
 rtl/ram_loader.sv | 167 ++++++++++++++++
 tb/tb_ram_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Word-wide single-port RAM with a CPU read/write port and a framed UART byte loader.
// Loader frame: MAGIC, ADDR[4] (byte address, LE), LEN[2] (LE), PAYLOAD[LEN], CSUM[1].
module ram_loader #(
  parameter int unsigned LOGD   = 10,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_REG = 0,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic            clk,
  input  logic            i_reset_n,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  input  logic [31:0]     rd_addr,
  output logic [DW-1:0]   rd_data,
  input  logic [31:0]     wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic            load_busy,
  output logic            load_done,
  output logic            load_err
);

  localparam int NB    = DW / 8;
  localparam int LB    = $clog2(NB);
  localparam int DEPTH = 1 << LOGD;

  typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StCsum} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_baddr, w_baddr_nxt;
  logic [15:0] r_len,   w_len_nxt;
  logic [1:0]  r_cnt,   w_cnt_nxt;
  logic [7:0]  r_csum,  w_csum_nxt;
  logic        r_rng,   w_rng_nxt;
  logic        r_err,   w_err_nxt;
  logic        r_done,  w_done_nxt;

  logic [DW-1:0]   r_mem [DEPTH];
  logic            w_oor;
  logic            w_ld_we;
  logic            w_cpu_we;
  logic [LB-1:0]   w_ld_lane;
  logic [NB-1:0]   w_lane_oh;
  logic [LOGD-1:0] w_widx;
  logic [DW-1:0]   w_wdata;
  logic [NB-1:0]   w_wbe;
  logic            w_unused;

  // Word index beyond the memory, including the region reached by 32-bit wrap.
  assign w_oor     = (r_baddr >> (LOGD + LB)) != 32'd0;
  assign w_ld_we   = rx_valid && (r_state == StData) && !w_oor;
  assign w_cpu_we  = wr_valid && !wr_addr[31] && !w_ld_we;
  assign w_ld_lane = r_baddr[LB-1:0];

  always_comb begin
    w_lane_oh            = '0;
    w_lane_oh[w_ld_lane] = 1'b1;
  end

  // Loader and CPU never write in the same cycle; the loader wins.
  assign w_widx  = w_ld_we ? r_baddr[LB +: LOGD] : wr_addr[LOGD-1:0];
  assign w_wdata = w_ld_we ? {NB{rx_data}} : wr_data;
  assign w_wbe   = w_ld_we ? w_lane_oh : (w_cpu_we ? wr_be : '0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_wbe[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
    end
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [DW-1:0] r_rd;
      always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) r_rd <= '0;
        else            r_rd <= r_mem[rd_addr[LOGD-1:0]];
      end
      assign rd_data = r_rd;
    end else begin : g_rd_comb
      assign rd_data = r_mem[rd_addr[LOGD-1:0]];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_baddr_nxt = r_baddr;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_csum_nxt  = r_csum;
    w_rng_nxt   = r_rng;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;
    if (rx_valid) begin
      case (r_state)
        StIdle: begin
          if (rx_data == MAGIC) begin
            w_state_nxt = StAddr;
            w_err_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_csum_nxt  = '0;
            w_rng_nxt   = 1'b0;
          end
        end
        StAddr: begin
          w_baddr_nxt = {rx_data, r_baddr[31:8]};
          w_cnt_nxt   = r_cnt + 2'd1;
          if (r_cnt == 2'd3) w_state_nxt = StLen;
        end
        StLen: begin
          w_len_nxt = {rx_data, r_len[15:8]};
          if (r_cnt == 2'd1) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (w_len_nxt == 16'd0) ? StCsum : StData;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
        StData: begin
          w_baddr_nxt = r_baddr + 32'd1;
          w_len_nxt   = r_len - 16'd1;
          w_csum_nxt  = r_csum + rx_data;
          if (w_oor) w_rng_nxt = 1'b1;
          if (r_len == 16'd1) w_state_nxt = StCsum;
        end
        StCsum: begin
          if ((rx_data == r_csum) && !r_rng) w_done_nxt = 1'b1;
          else                               w_err_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_baddr <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_rng   <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baddr <= w_baddr_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_csum  <= w_csum_nxt;
      r_rng   <= w_rng_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign wr_ready  = !w_ld_we;
  assign load_busy = (r_state != StIdle);
  assign load_done = r_done;
  assign load_err  = r_err;

  // Upper address bits carry no meaning for the memory itself.
  assign w_unused = ^{rd_addr[31:LOGD], wr_addr[30:LOGD]};

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a byte-array memory model plus frame-level expectations,
// applied to a combinational-read and a registered-read instance driven in parallel.
module tb_ram_loader;

  localparam int MEMB = 4096;  // bytes in a 1024 x 32-bit memory

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_be;
  logic        wr_valid;
  logic [31:0] rd0, rd1;
  logic        ready0, ready1, busy0, busy1, done0, done1, err0, err1;

  always #5 clk = ~clk;

  ram_loader #(.LOGD(10), .DW(32), .RD_REG(0), .MAGIC(8'hA5)) u_dut0 (
    .clk(clk), .i_reset_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rd_addr(rd_addr), .rd_data(rd0), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_valid(wr_valid), .wr_ready(ready0), .load_busy(busy0),
    .load_done(done0), .load_err(err0)
  );

  ram_loader #(.LOGD(10), .DW(32), .RD_REG(1), .MAGIC(8'hA5)) u_dut1 (
    .clk(clk), .i_reset_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rd_addr(rd_addr), .rd_data(rd1), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_valid(wr_valid), .wr_ready(ready1), .load_busy(busy1),
    .load_done(done1), .load_err(err1)
  );

  logic [7:0]  mem_b [MEMB];
  logic        m_ldw;
  logic        e_busy, e_done, e_err;
  logic [31:0] e_rd1;
  logic        mdl_busy, mdl_err;
  logic        cpu_rand, cpu_held, mem_known, coll_arm;
  logic [9:0]  bias_word;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;

  function automatic logic [31:0] mword(input int unsigned a);
    return {mem_b[4*a+3], mem_b[4*a+2], mem_b[4*a+1], mem_b[4*a]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic rand_cpu();
    logic       mm;
    logic [9:0] w;
    if (!cpu_held) begin
      mm       = ($urandom_range(0, 7) == 0);
      w        = ($urandom_range(0, 1) == 1) ? bias_word : 10'($urandom);
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = {mm, 21'd0, w};
      wr_data  = $urandom;
      wr_be    = 4'($urandom);
    end
    rd_addr = $urandom;
    if ($urandom_range(0, 1) == 1) rd_addr[9:0] = bias_word;
  endtask

  // One clock: drive this cycle's inputs, then apply the edge to the model.
  task automatic step(input logic rv, input logic [7:0] rd, input logic ldw,
                      input logic [31:0] lba, input logic nb, input logic nd, input logic ne);
    int unsigned base;
    rx_valid = rv;
    rx_data  = rd;
    m_ldw    = ldw;
    if (cpu_rand) rand_cpu();
    @(posedge clk);
    if (!rst_n) begin
      e_rd1 = '0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      e_rd1 = mword(32'(rd_addr[9:0]));
      if (ldw) begin
        mem_b[lba] = rx_data;
      end else if (wr_valid && !wr_addr[31]) begin
        base = 32'(wr_addr[9:0]) * 4;
        for (int i = 0; i < 4; i++) if (wr_be[i]) mem_b[base+i] = wr_data[8*i +: 8];
      end
      e_busy = nb; e_done = nd; e_err = ne;
    end
    cpu_held = wr_valid && ldw;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'($urandom), 1'b0, 32'd0, mdl_busy, 1'b0, mdl_err);
  endtask

  task automatic gap(input logic g);
    if (g) repeat ($urandom_range(0, 2)) idle();
  endtask

  task automatic frame(input logic [31:0] addr, input logic [7:0] pl[$], input int csum,
                       input logic gaps, input logic hdr_only);
    logic [7:0]  sum, c;
    logic [31:0] a;
    logic [15:0] len;
    logic        rng, ok;
    sum = 8'd0; rng = 1'b0; len = 16'(pl.size());
    foreach (pl[i]) begin
      sum += pl[i];
      a = addr + 32'(i);
      if (a >= MEMB) rng = 1'b1;
    end
    bias_word = addr[11:2];
    gap(gaps);
    step(1'b1, 8'hA5, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    mdl_busy = 1'b1; mdl_err = 1'b0;
    chk("magic_clears_err", {31'd0, err0}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      gap(gaps);
      step(1'b1, addr[8*k +: 8], 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      gap(gaps);
      step(1'b1, len[8*k +: 8], 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    end
    if (hdr_only) return;
    foreach (pl[i]) begin
      a = addr + 32'(i);
      gap(gaps);
      if (coll_arm && i == 0) begin
        wr_valid = 1'b1; wr_addr = 32'd1; wr_data = 32'h5566_7788; wr_be = 4'hF;
        rx_valid = 1'b1; rx_data = pl[0];
        #1;
        chk("coll_ready0", {31'd0, ready0}, 32'd0);
        chk("coll_ready1", {31'd0, ready1}, 32'd0);
      end
      step(1'b1, pl[i], (a < MEMB), a, 1'b1, 1'b0, 1'b0);
      if (coll_arm && i == 0) begin
        rd_addr = 32'd1; #1;
        chk("coll_loader_only", rd0, 32'h00BE_AD77);
      end
    end
    c  = (csum < 0) ? sum : csum[7:0];
    ok = (c == sum) && !rng;
    gap(gaps);
    step(1'b1, c, 1'b0, 32'd0, 1'b0, ok, !ok);
    mdl_busy = 1'b0; mdl_err = !ok;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_known) begin
        chk("rd_comb", rd0, mword(32'(rd_addr[9:0])));
        chk("rd_reg", rd1, e_rd1);
      end
      chk("wr_ready0", {31'd0, ready0}, {31'd0, !m_ldw});
      chk("wr_ready1", {31'd0, ready1}, {31'd0, !m_ldw});
      chk("busy", {30'd0, busy1, busy0}, {30'd0, e_busy, e_busy});
      chk("done", {30'd0, done1, done0}, {30'd0, e_done, e_done});
      chk("err", {30'd0, err1, err0}, {30'd0, e_err, e_err});
      if (done0) done_cnt++;
    end
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] jb;
    logic [31:0] ad;
    int kind, l, cs, dc;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rd_addr = '0; wr_addr = '0;
    wr_data = '0; wr_be = '0; wr_valid = 1'b0; m_ldw = 1'b0; cpu_rand = 1'b0;
    cpu_held = 1'b0; mem_known = 1'b0; coll_arm = 1'b0; bias_word = '0;
    mdl_busy = 1'b0; mdl_err = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_rd1 = '0;
    foreach (mem_b[i]) mem_b[i] = 8'd0;
    #3;
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_rd_reg", rd1, 32'd0);
    idle(); idle();
    rst_n = 1'b1;

    // Bring every word to a known zero.
    for (int w = 0; w < 1024; w++) begin
      wr_valid = 1'b1; wr_addr = 32'(w); wr_data = '0; wr_be = 4'hF;
      idle();
    end
    wr_valid = 1'b0;
    idle();
    mem_known = 1'b1;

    // CPU byte-enable write.
    wr_valid = 1'b1; wr_addr = 32'd5; wr_data = 32'h1122_3344; wr_be = 4'b1111; idle();
    wr_data = 32'hAABB_CCDD; wr_be = 4'b0100; idle();
    wr_valid = 1'b0; rd_addr = 32'd5; #1;
    chk("cpu_be_comb", rd0, 32'h11BB_3344);
    idle();
    chk("cpu_be_reg", rd1, 32'h11BB_3344);

    // Good frame to word 1.
    dc = done_cnt;
    pl = '{8'hDE, 8'hAD, 8'hBE};
    frame(32'd4, pl, 'h49, 1'b0, 1'b0);
    idle();
    rd_addr = 32'd1; #1;
    chk("frame_mem1", rd0, 32'h00BE_ADDE);
    chk("frame_done_once", 32'(done_cnt - dc), 32'd1);
    chk("frame_busy_off", {31'd0, busy0}, 32'd0);
    chk("frame_err_clear", {31'd0, err0}, 32'd0);

    // Same frame, bad checksum.
    dc = done_cnt;
    frame(32'd4, pl, 'h00, 1'b0, 1'b0);
    idle(); idle();
    chk("badcs_err", {31'd0, err0}, 32'd1);
    chk("badcs_no_done", 32'(done_cnt - dc), 32'd0);

    // Last byte of memory, second byte out of range.
    pl = '{8'h3C, 8'h5A};
    frame(32'd4095, pl, -1, 1'b0, 1'b0);
    idle();
    rd_addr = 32'd1023; #1;
    chk("range_lane3", rd0, 32'h3C00_0000);
    chk("range_err", {31'd0, err0}, 32'd1);

    // CPU write colliding with a loader byte to word 1.
    coll_arm = 1'b1;
    pl = '{8'h77};
    frame(32'd4, pl, 'h77, 1'b0, 1'b0);
    coll_arm = 1'b0;
    wr_valid = 1'b0; rd_addr = 32'd1; #1;
    chk("coll_cpu_after", rd0, 32'h5566_7788);
    idle();

    // Asynchronous reset after the LEN bytes.
    pl = '{8'h11, 8'h22, 8'h33};
    frame(32'd32, pl, -1, 1'b0, 1'b1);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    mdl_busy = 1'b0; mdl_err = 1'b0; m_ldw = 1'b0;
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_rd1 = '0;
    #1;
    chk("async_rst_busy0", {31'd0, busy0}, 32'd0);
    chk("async_rst_busy1", {31'd0, busy1}, 32'd0);
    idle(); idle();
    rst_n = 1'b1;
    foreach (pl[i]) step(1'b1, pl[i], 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    rd_addr = 32'd8; #1;
    chk("rst_no_write", rd0, 32'd0);

    // Randomized frames with concurrent CPU traffic.
    cpu_rand = 1'b1;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      l    = $urandom_range(0, 10);
      pl.delete();
      for (int j = 0; j < l; j++) pl.push_back(8'($urandom));
      cs = -1;
      if (kind == 6 || kind == 7) cs = $urandom_range(0, 255);
      if (kind == 8)      ad = 32'(MEMB - 1 - $urandom_range(0, 3));
      else if (kind == 9) ad = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
      else                ad = 32'($urandom_range(0, MEMB - 1 - l));
      frame(ad, pl, cs, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h00;
        step(1'b1, jb, 1'b0, 32'd0, 1'b0, 1'b0, mdl_err);
      end
    end
    cpu_rand = 1'b0; wr_valid = 1'b0;
    idle(); idle(); idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
